// File: rtl/logic_gate_array.sv
// Multi-lane selectable bitwise gate (AND/OR/XOR/NAND) feeding a DEPTH-entry
// output FIFO with valid/ready on both sides and a wrapping delivered-result counter.
module logic_gate_array #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_a,
  input  logic [CHANNELS*WIDTH-1:0]    in_b,
  input  logic [1:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_x,
  output logic [1:0]                   out_op,
  output logic [CHANNELS-1:0]          out_allones,
  output logic [CNT_W-1:0]             out_count
);

  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  logic [DW-1:0]       mem_x   [DEPTH];
  logic [1:0]          mem_op  [DEPTH];
  logic [CHANNELS-1:0] mem_all [DEPTH];

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [OW-1:0]       occ;
  logic [DW-1:0]       x_c;
  logic [CHANNELS-1:0] allones_c;
  logic                push;
  logic                pop;

  // Handshake flags depend only on registered occupancy
  assign in_ready  = (occ != OW'(DEPTH));
  assign out_valid = (occ != OW'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Per-lane bitwise operation on the incoming operands
  always_comb begin
    x_c = '0;
    case (in_op)
      OP_AND:  x_c = in_a & in_b;
      OP_OR:   x_c = in_a | in_b;
      OP_XOR:  x_c = in_a ^ in_b;
      OP_NAND: x_c = ~(in_a & in_b);
      default: x_c = '0;
    endcase
  end

  always_comb begin
    allones_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      allones_c[k] = &x_c[k*WIDTH +: WIDTH];
    end
  end

  // Storage is never cleared; the output mux below hides stale entries
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_x[wr_ptr]   <= x_c;
      mem_op[wr_ptr]  <= in_op;
      mem_all[wr_ptr] <= allones_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_count <= out_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign out_x       = out_valid ? mem_x[rd_ptr]   : '0;
  assign out_op      = out_valid ? mem_op[rd_ptr]  : 2'd0;
  assign out_allones = out_valid ? mem_all[rd_ptr] : '0;

endmodule

// File: tb/tb_logic_gate_array.sv
// Directed bench for logic_gate_array: truth table, backpressure, drain,
// steady push/pop, counter wrap (CNT_W=4 instance) and mid-stream reset.
module tb_logic_gate_array;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_x;
  logic [1:0]  out_op;
  logic [3:0]  out_allones;
  logic [15:0] out_count;

  logic        w_in_ready, w_out_valid;
  logic [31:0] w_out_x;
  logic [1:0]  w_out_op;
  logic [3:0]  w_out_allones;
  logic [3:0]  w_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference queue of expected head values; stimulus outside the truth table
  // uses AND with all-ones b, so each result equals its operand a.
  logic [31:0] mq[$];
  int          mcount = 0;

  logic gap_seen;

  logic_gate_array #(.WIDTH(8), .CHANNELS(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_op(out_op),
    .out_allones(out_allones), .out_count(out_count)
  );

  logic_gate_array #(.WIDTH(8), .CHANNELS(4), .DEPTH(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_x(w_out_x), .out_op(w_out_op),
    .out_allones(w_out_allones), .out_count(w_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    bit p, q;
    p = in_valid && (mq.size() < D);
    q = out_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      mcount = 0;
    end else begin
      if (q) begin
        void'(mq.pop_front());
        mcount++;
      end
      if (p) mq.push_back(in_a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", out_count); else pass_cnt++;
    total_cnt++; if (out_x !== 32'h0) $display("FAIL reset_out_x got %h exp 0", out_x); else pass_cnt++;
    total_cnt++; if (out_op !== 2'd0) $display("FAIL reset_out_op got %0d exp 0", out_op); else pass_cnt++;
    total_cnt++; if (out_allones !== 4'd0) $display("FAIL reset_allones got %b exp 0", out_allones); else pass_cnt++;
  endtask

  task automatic test_truth_table();
    logic [31:0] ex [4];
    logic [3:0]  ea [4];
    ex[0] = 32'h0000FF00; ea[0] = 4'b0010;
    ex[1] = 32'hFFFFFF00; ea[1] = 4'b1110;
    ex[2] = 32'hFFFF0000; ea[2] = 4'b1100;
    ex[3] = 32'hFFFF00FF; ea[3] = 4'b1101;
    do_reset();
    out_ready = 1'b1;
    in_a = {8'hAA, 8'hF0, 8'hFF, 8'h00};
    in_b = {8'h55, 8'h0F, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op = 2'(i);
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL tt_valid op%0d got %b exp 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_x !== ex[i]) $display("FAIL tt_x op%0d got %h exp %h", i, out_x, ex[i]); else pass_cnt++;
      total_cnt++; if (out_op !== 2'(i)) $display("FAIL tt_op op%0d got %0d exp %0d", i, out_op, i); else pass_cnt++;
      total_cnt++; if (out_allones !== ea[i]) $display("FAIL tt_allones op%0d got %b exp %b", i, out_allones, ea[i]); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL tt_empty got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_count !== 16'd4) $display("FAIL tt_count got %0d exp 4", out_count); else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset();
    out_ready = 1'b0;
    in_b = 32'hFFFFFFFF;
    in_op = 2'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 32'h01010101 * 32'(i + 1);
      step();
      total_cnt++; if (in_ready !== (i < 3)) $display("FAIL fill_in_ready push%0d got %b exp %b", i, in_ready, (i < 3)); else pass_cnt++;
    end
    total_cnt++; if (out_x !== 32'h01010101) $display("FAIL fill_head got %h exp 01010101", out_x); else pass_cnt++;
    total_cnt++; if (out_op !== 2'd0) $display("FAIL fill_head_op got %0d exp 0", out_op); else pass_cnt++;
    total_cnt++; if (out_allones !== 4'b0000) $display("FAIL fill_head_allones got %b exp 0", out_allones); else pass_cnt++;
  endtask

  // Continues from the full FIFO left by test_fill
  task automatic test_drain();
    gap_seen = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_a = 32'hA0000000 + 32'(j);
      step();
      if (j == 0) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL drain_ready_back got %b exp 1", in_ready); else pass_cnt++;
      end
      if (out_valid !== 1'b1 || mq.size() == 0) gap_seen = 1'b1;
      else begin
        total_cnt++; if (out_x !== mq[0]) $display("FAIL drain_order step%0d got %h exp %h", j, out_x, mq[0]); else pass_cnt++;
      end
      total_cnt++; if (out_count !== 16'(mcount)) $display("FAIL drain_count step%0d got %0d exp %0d", j, out_count, mcount); else pass_cnt++;
    end
    total_cnt++; if (gap_seen !== 1'b0) $display("FAIL drain_gap got 1 exp 0"); else pass_cnt++;
    total_cnt++; if (out_count !== 16'd8) $display("FAIL drain_total got %0d exp 8", out_count); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    in_b = 32'hFFFFFFFF;
    in_op = 2'd0;
    in_valid = 1'b1;
    in_a = 32'h11111111; step();
    in_a = 32'h22222222; step();
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_a = 32'hB0000000 + 32'(j);
      step();
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready step%0d got %b exp 1", j, in_ready); else pass_cnt++;
      if (mq.size() > 0) begin
        total_cnt++; if (out_x !== mq[0]) $display("FAIL b2b_order step%0d got %h exp %h", j, out_x, mq[0]); else pass_cnt++;
      end
    end
    total_cnt++; if (out_count !== 16'd10) $display("FAIL b2b_count got %0d exp 10", out_count); else pass_cnt++;
    total_cnt++; if (out_x !== 32'hB0000008) $display("FAIL b2b_head got %h exp b0000008", out_x); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_occ_last got %b exp 1", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_occ_empty got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_b = 32'hFFFFFFFF;
    in_op = 2'd0;
    for (int k = 1; k <= 18; k++) begin
      in_a = 32'(k);
      step();
      if (k == 16) begin
        total_cnt++; if (w_count !== 4'd15) $display("FAIL wrap_15 got %0d exp 15", w_count); else pass_cnt++;
      end
      if (k == 17) begin
        total_cnt++; if (w_count !== 4'd0) $display("FAIL wrap_0 got %0d exp 0", w_count); else pass_cnt++;
      end
      if (k == 18) begin
        total_cnt++; if (w_count !== 4'd1) $display("FAIL wrap_1 got %0d exp 1", w_count); else pass_cnt++;
      end
    end
    total_cnt++; if (out_count !== 16'd17) $display("FAIL wrap_wide got %0d exp 17", out_count); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_b = 32'hFFFFFFFF;
    in_op = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'hC0000000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_count !== 16'd1) $display("FAIL mid_precount got %0d exp 1", out_count); else pass_cnt++;
    out_ready = 1'b0;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 32'hDEADBEEF;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_count !== 16'd0) $display("FAIL mid_count got %0d exp 0", out_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_x !== 32'h0) $display("FAIL mid_out_x got %h exp 0", out_x); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_lost_push got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_count !== 16'd0) $display("FAIL mid_no_stale got %0d exp 0", out_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_fill();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/logic_gate_array.md
# logic_gate_array

Parametrised, pipelined successor to the single two-input AND gate: applies a selectable bitwise operation (AND, OR, XOR, NAND) to CHANNELS independent WIDTH-bit operand pairs per transaction. Results are stored in a DEPTH-entry output FIFO with valid/ready handshakes on both sides. A wrapping counter records delivered results. The block sits between operand producers and downstream consumers in the glue-logic datapath.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, independent lanes per transaction (≥1)
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- CNT_W, 16, width of delivered-result counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept; equals !full
- in_a  in  CHANNELS*WIDTH  operand A; lane k = bits [k*WIDTH +: WIDTH]
- in_b  in  CHANNELS*WIDTH  operand B, same lane packing
- in_op  in  2  0=AND, 1=OR, 2=XOR, 3=NAND
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer accepts head
- out_x  out  CHANNELS*WIDTH  result at FIFO head
- out_op  out  2  opcode that produced the head result
- out_allones  out  CHANNELS  bit k = reduction-AND of lane k of out_x
- out_count  out  CNT_W  number of results delivered, modulo 2^CNT_W

## Operation
- Accept (push) when in_valid && in_ready on a rising clk edge. Compute per-lane x = a OP b, bitwise; NAND = ~(a & b). Write {x, in_op} into FIFO tail.
- Deliver (pop) when out_valid && out_ready. out_count increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- FIFO: write pointer, read pointer, occupancy 0..DEPTH. full = (occupancy == DEPTH). empty = (occupancy == 0). Pointers wrap modulo DEPTH.
- in_ready = !full, registered-state based and never dependent on out_ready. There is no combinational path out_ready → in_ready.
- out_valid = !empty. out_x, out_op and out_allones come straight from the head entry.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged and both pointers advance.
- Simultaneous push and pop when full: only the pop happens, because in_ready is low.
- Empty: no bypass. A pushed result appears at the head only on the following cycle.
- in_op is sampled only at push. Operand and opcode values while in_valid is low are ignored.
- out_x, out_op and out_allones are held stable while out_valid && !out_ready.
- Reset overrides all activity in the same cycle: a push or pop coinciding with rst is discarded. Reset values:
  - pointers 0, occupancy 0
  - in_ready 1 (the cycle after reset)
  - out_valid 0, out_count 0, out_x 0, out_op 0, out_allones 0
  - Stored FIFO data need not be cleared, but outputs must read 0 while empty.
- Inputs known ⇒ all outputs known (no X after reset).

## Timing
- Latency: push at edge N ⇒ out_valid=1 with that result after edge N (visible in cycle N+1), if the FIFO was empty.
- Throughput: one transaction per cycle sustained when out_ready is held high.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- out_count updates on the same edge as the pop it counts.
- Mid-operation reset: occupancy and count are 0 in the cycle after the rst edge, and in_ready is 1.

## Test plan
- Truth table: WIDTH=8, CHANNELS=4, each op with lanes a={00,FF,F0,AA}, b={00,FF,0F,55}, out_ready=1.
  - Expect AND={00,FF,00,00} with allones=0010
  - OR={00,FF,FF,FF} with allones=1110
  - XOR={00,00,FF,FF}
  - NAND={FF,00,FF,FF}
  - Each appears one cycle after push.
- Fill/backpressure: out_ready=0, push 5 transactions with DEPTH=4.
  - Only 4 accepted; in_ready=0 after the 4th.
  - Head remains the 1st result, unchanged.
- Drain from full: set out_ready=1 with in_valid held high.
  - in_ready returns one cycle after the first pop.
  - Results emerge in push order; out_count goes 0→4 and beyond without gaps.
- Simultaneous push/pop at occupancy 2 for 10 cycles: occupancy stays 2, output order preserved, out_count +10.
- Counter wrap: CNT_W=4, deliver 17 results; out_count reads 15 then 0 then 1.
- Reset mid-stream: assert rst with 3 entries queued and in_valid=1.
  - Next cycle: out_valid=0, out_count=0, in_ready=1.
  - The push in the reset cycle is lost; no stale data is emitted.
